// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: two-entry (main + skid) buffer with a registered in_ready and a built-in write-back mux.
// Optional forwarding outputs (fwd_valid/fwd_rw/fwd_data) are enabled by defining MEM_WB_FWD_EN.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [RA_W-1:0]   in_rw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_regwrite,
  output logic [RA_W-1:0]   out_rw,
  output logic [DATA_W-1:0] out_wb_data
`ifdef MEM_WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [RA_W-1:0]   fwd_rw,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef struct packed {
    logic              memtoreg;
    logic              regwrite;
    logic [RA_W-1:0]   rw;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, state_nxt;
  logic   in_ready_q, in_ready_nxt;
  logic   load_main, load_skid, skid_to_main;
  entry_t in_entry_p0;
  entry_t main_p1, skid_p1;

  // Writes to r0 are dropped at capture so the head never advertises them.
  function automatic entry_t capture(input logic memtoreg, input logic regwrite,
                                     input logic [RA_W-1:0] rw,
                                     input logic [DATA_W-1:0] mem_data,
                                     input logic [DATA_W-1:0] alu);
    entry_t e;
    e.memtoreg = memtoreg;
    e.regwrite = regwrite & (rw != '0);
    e.rw       = rw;
    e.mem_data = mem_data;
    e.alu      = alu;
    return e;
  endfunction

  function automatic logic [DATA_W-1:0] wb_select(input entry_t e);
    return e.memtoreg ? e.mem_data : e.alu;
  endfunction

  assign in_entry_p0 = capture(in_memtoreg, in_regwrite, in_rw, in_mem_data, in_alu);

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: begin
        if (in_valid) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_valid && out_ready) begin
          load_main = 1'b1;
        end else if (in_valid) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          skid_to_main = 1'b1;
          state_nxt    = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush overrides every move, including a same-cycle input transfer.
    if (flush) begin
      state_nxt    = EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
    in_ready_nxt = (state_nxt != FULL);
  end

  // Stage boundary: main/skid slots register the MEM-side entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_p1    <= '0;
      skid_p1    <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= in_ready_nxt;
      if (load_main)
        main_p1 <= in_entry_p0;
      else if (skid_to_main)
        main_p1 <= skid_p1;
      if (load_skid)
        skid_p1 <= in_entry_p0;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state != EMPTY);
  assign out_regwrite = out_valid & main_p1.regwrite;
  assign out_rw       = out_valid ? main_p1.rw : '0;
  assign out_wb_data  = out_valid ? wb_select(main_p1) : '0;

`ifdef MEM_WB_FWD_EN
  assign fwd_valid = out_valid & out_regwrite;
  assign fwd_rw    = out_rw;
  assign fwd_data  = out_wb_data;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, hand-written reset/stream sequences,
// and randomized traffic checked against a queue-based model of the two-entry stage.
module tb_mem_wb_stage;
  localparam int DATA_W = 32;
  localparam int RA_W   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_memtoreg;
  logic              in_regwrite;
  logic [DATA_W-1:0] in_mem_data;
  logic [DATA_W-1:0] in_alu;
  logic [RA_W-1:0]   in_rw;
  logic              out_valid;
  logic              out_ready;
  logic              out_regwrite;
  logic [RA_W-1:0]   out_rw;
  logic [DATA_W-1:0] out_wb_data;
`ifdef MEM_WB_FWD_EN
  logic              fwd_valid;
  logic [RA_W-1:0]   fwd_rw;
  logic [DATA_W-1:0] fwd_data;
`endif

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite),
    .in_mem_data(in_mem_data), .in_alu(in_alu), .in_rw(in_rw),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_regwrite(out_regwrite), .out_rw(out_rw), .out_wb_data(out_wb_data)
`ifdef MEM_WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rw(fwd_rw), .fwd_data(fwd_data)
`endif
  );

  // Packed view {out_valid, in_ready, out_regwrite, out_rw, out_wb_data}
  typedef logic [39:0] obs_t;

  typedef struct {
    logic        iv, m2r, rwe;
    logic [31:0] mem, alu;
    logic [4:0]  rw;
    logic        ordy, fl;
    obs_t        exp;
  } vec_t;

  typedef struct {
    logic        m2r, rwe;
    logic [4:0]  rw;
    logic [31:0] mem, alu;
  } ent_t;

  ent_t q[$];
  vec_t tbl[10];
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic obs_t observed();
    return {out_valid, in_ready, out_regwrite, out_rw, out_wb_data};
  endfunction

  function automatic obs_t model_obs();
    ent_t h;
    if (q.size() == 0) return {1'b0, 1'b1, 1'b0, 5'd0, 32'd0};
    h = q[0];
    return {1'b1, (q.size() < 2), (h.rwe && h.rw != 0), h.rw, (h.m2r ? h.mem : h.alu)};
  endfunction

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%b rdy=%b rw_en=%b rw=%0d wb=%h, want v=%b rdy=%b rw_en=%b rw=%0d wb=%h",
               nm, act[39], act[38], act[37], act[36:32], act[31:0],
               exp[39], exp[38], exp[37], exp[36:32], exp[31:0]);
    end
  endtask

  task automatic chk_fwd(input string nm, input obs_t exp);
`ifdef MEM_WB_FWD_EN
    logic [38:0] a, e;
    a = {fwd_valid, fwd_rw, fwd_data};
    e = {exp[39] & exp[37], exp[36:32], exp[31:0]};
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got fwd=%h, want %h", nm, a, e);
    end
`else
    if (nm.len() < 0) $display("%h", exp);
`endif
  endtask

  task automatic drive(input logic iv, input logic m2r, input logic rwe, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] rw, input logic ordy, input logic fl);
    in_valid = iv; in_memtoreg = m2r; in_regwrite = rwe; in_mem_data = mem;
    in_alu = alu; in_rw = rw; out_ready = ordy; flush = fl;
  endtask

  // Advance the reference model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    ent_t e;
    logic in_x, out_x;
    in_x  = in_valid && (q.size() < 2);
    out_x = out_ready && (q.size() > 0);
    if (flush) begin
      q.delete();
    end else begin
      if (out_x) void'(q.pop_front());
      if (in_x) begin
        e.m2r = in_memtoreg; e.rwe = in_regwrite; e.rw = in_rw;
        e.mem = in_mem_data; e.alu = in_alu;
        q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'd5,    5'd3, 1'b0, 1'b0, {1'b1, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF}};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h12345678, 32'd9,    5'd0, 1'b1, 1'b0, {1'b1, 1'b1, 1'b0, 5'd0, 32'h12345678}};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 32'd0,        32'd0,    5'd0, 1'b1, 1'b0, {1'b0, 1'b1, 1'b0, 5'd0, 32'd0}};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'hFF,       32'h11,   5'd4, 1'b0, 1'b0, {1'b1, 1'b1, 1'b1, 5'd4, 32'h11}};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'hFF,       32'h22,   5'd5, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 5'd4, 32'h11}};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 32'hFF,       32'h33,   5'd6, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 5'd4, 32'h11}};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 32'hFF,       32'h33,   5'd6, 1'b1, 1'b0, {1'b1, 1'b1, 1'b0, 5'd5, 32'h22}};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 32'hFF,       32'h33,   5'd6, 1'b0, 1'b0, {1'b1, 1'b0, 1'b0, 5'd5, 32'h22}};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 32'hFF,       32'h44,   5'd7, 1'b1, 1'b1, {1'b0, 1'b1, 1'b0, 5'd0, 32'd0}};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 32'd0,        32'd0,    5'd0, 1'b1, 1'b0, {1'b0, 1'b1, 1'b0, 5'd0, 32'd0}};

    // Reset held while upstream offers an entry
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'hAA, 32'h77, 5'd2, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", observed(), {1'b0, 1'b1, 1'b0, 5'd0, 32'd0});
    rst_n = 1'b1;
    q.delete();
    tick();
    chk("first_after_reset", observed(), {1'b1, 1'b1, 1'b1, 5'd2, 32'h77});
    chk_fwd("fwd_head_held", {1'b1, 1'b1, 1'b1, 5'd2, 32'h77});
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    tick();
    chk("drain_after_reset", observed(), {1'b0, 1'b1, 1'b0, 5'd0, 32'd0});

    // Back-to-back stream with out_ready high
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'hFFFF_0000, 32'(i), 5'(i + 1), 1'b1, 1'b0);
      tick();
      chk($sformatf("stream_%0d", i), observed(), {1'b1, 1'b1, 1'b1, 5'(i + 1), 32'(i)});
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    tick();
    chk("stream_end", observed(), {1'b0, 1'b1, 1'b0, 5'd0, 32'd0});

    // Directed table: mux, r0 suppression, backpressure, skid, flush
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].iv, tbl[i].m2r, tbl[i].rwe, tbl[i].mem, tbl[i].alu, tbl[i].rw, tbl[i].ordy, tbl[i].fl);
      tick();
      chk($sformatf("vec_%0d", i), observed(), tbl[i].exp);
      chk_fwd($sformatf("vec_fwd_%0d", i), tbl[i].exp);
    end

    // Forwarding with head stalled: alu=0x40 rw=7
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h40, 5'd7, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("stall_head", observed(), {1'b1, 1'b1, 1'b1, 5'd7, 32'h40});
    chk_fwd("fwd_stall", {1'b1, 1'b1, 1'b1, 5'd7, 32'h40});

    // Randomized traffic against the queue model
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    tick();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom), $urandom, $urandom,
            (($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom)),
            ($urandom_range(0, 9) < 5), ($urandom_range(0, 29) == 0));
      tick();
      chk($sformatf("rand_%0d", c), observed(), model_obs());
      chk_fwd($sformatf("rand_fwd_%0d", c), model_obs());
    end

    // Asynchronous reset while FULL drops everything immediately
    drive(1'b1, 1'b0, 1'b1, 32'd0, 32'h5A, 5'd9, 1'b0, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_midop", observed(), {1'b0, 1'b1, 1'b0, 5'd0, 32'd0});
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    tick();
    chk("after_midop_reset", observed(), {1'b0, 1'b1, 1'b0, 5'd0, 32'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
